// File: rtl/multi_nibble_add_seq_if.sv
// Bus bundle for the nibble-serial adder: request side (start, mode,
// operands) and response side (busy/done strobes, result and flags).
interface multi_nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic                   sub;
    logic                   cin;
    logic [4*NIBBLES-1:0]   op_a;
    logic [4*NIBBLES-1:0]   op_b;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   result;
    logic                   cout;
    logic                   overflow;

    modport master (
        output start, sub, cin, op_a, op_b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, cin, op_a, op_b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/multi_nibble_add_seq.sv
// Nibble-serial adder/subtractor. A single 4-bit ripple slice is reused once
// per clock, LSB nibble first; subtraction is done as A + ~B + 1.
module multi_nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_nibble_add_seq_if.slave   bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One 4-bit ripple slice: returns {overflow, carry_out, sum[3:0]}.
    // Overflow is the carry into bit 3 XOR the carry out of bit 3.
    function automatic logic [5:0] nibble_add(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic       c);
        logic [3:0] low;
        logic [1:0] top;
        low = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, c};
        top = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low[3]};
        return {low[3] ^ top[1], top[1], top[0], low[2:0]};
    endfunction

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       result_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [3:0]         a_nib_s;
    logic [3:0]         b_nib_s;
    logic [5:0]         slice_d;
    logic [W-1:0]       result_d;

    // Select the current nibble pair, run the slice, and merge its sum into
    // the result at the current index.
    always_comb begin
        a_nib_s  = 4'(a_q >> {idx_q, 2'b00});
        b_nib_s  = 4'(b_q >> {idx_q, 2'b00});
        slice_d  = nibble_add(a_nib_s, b_nib_s, carry_q);
        result_d = result_q;
        for (int n = 0; n < NIBBLES; n++) begin
            result_d[4*n +: 4] = (idx_q == IDX_W'(n)) ? slice_d[3:0]
                                                      : result_q[4*n +: 4];
        end
    end

    // Control FSM with registered busy/done strobes and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IDX_W{1'b0}};
            carry_q  <= 1'b0;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            result_q <= {W{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        idx_q   <= {IDX_W{1'b0}};
                        state_q <= ST_ADD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_ADD: begin
                    result_q <= result_d;
                    carry_q  <= slice_d[4];
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_d[4];
                        ovf_q   <= slice_d[5];
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + IDX_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/multi_nibble_add_seq.md
MULTI_NIBBLE_ADD_SEQ -- requirements
Module: multi_nibble_add_seq

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 4, number of 4-bit slices per operand; legal range 1..16.
REQ-002 The block SHALL have one clock, clk, and reset is asynchronous and active-high, named rst.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request pulse; operands are sampled on the accepting edge.
REQ-006 Port: sub  input  1  0 = add, 1 = subtract (A - B); sampled with start.
REQ-007 Port: cin  input  1  carry-in for add; ignored when sub=1.
REQ-008 Port: op_a  input  4*NIBBLES  operand A, unsigned or two's complement.
REQ-009 Port: op_b  input  4*NIBBLES  operand B.
REQ-010 Port: busy  output  1  high while slices are being processed.
REQ-011 Port: done  output  1  one-cycle pulse when result is valid.
REQ-012 Port: result  output  4*NIBBLES  sum or difference.
REQ-013 Port: cout  output  1  final carry-out; for subtract, 1 = no borrow.
REQ-014 Port: overflow  output  1  signed overflow flag.

Function
REQ-015 The block SHALL compute the full-width result by time-sharing a single 4-bit ripple full-adder slice, one nibble per clock, LSB nibble first.
REQ-016 FSM states SHALL be IDLE, ADD and DONE.
REQ-017 IDLE or DONE with start=1 SHALL latch op_a, op_b (inverted when sub=1) and sub, clear the nibble index, load the carry register with (sub ? 1 : cin), and go to ADD.
REQ-018 IDLE or DONE with start=0: IDLE holds; DONE returns to IDLE.
REQ-019 Each ADD cycle SHALL add nibble[idx] of A, B and the carry register, write the 4-bit sum into result nibble idx, update the carry register, and increment idx.
REQ-020 When idx = NIBBLES-1 the ADD cycle SHALL also capture cout = slice carry-out and overflow = (carry into bit 3) XOR (carry out of bit 3) of that slice, then go to DONE.
REQ-021 Latency: start accepted at edge t SHALL give done=1 in the cycle following edge t+NIBBLES; busy=1 exactly NIBBLES cycles.
REQ-022 busy SHALL be 1 in ADD only; done SHALL be 1 in DONE only.
REQ-023 start while in ADD SHALL be ignored with no effect on operands, state or outputs.
REQ-024 start in DONE SHALL be accepted (back-to-back), with done still pulsing that cycle.
REQ-025 result, cout and overflow SHALL hold their last values from DONE until the next accepted start; nibbles of result not yet written during ADD are don't-care.
REQ-026 NIBBLES=1 SHALL give a single ADD cycle and is a legal boundary.
REQ-027 The index counter SHALL be ceil(log2(NIBBLES)) bits, minimum 1, and SHALL NOT wrap within an operation.

Reset
REQ-028 rst=1 SHALL, asynchronously, force state IDLE, idx=0, carry register 0, busy=0, done=0, result=0, cout=0 and overflow=0.
REQ-029 rst asserted during ADD SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL run a full operation.
REQ-030 start coincident with the first clock edge after rst deasserts SHALL be accepted.

Verification (NIBBLES=4)
REQ-031 The bench SHALL check: op_a=0x1234, op_b=0x4321, cin=0, sub=0 -> result=0x5555, cout=0, overflow=0, done 5 cycles after start, busy for 4 cycles.
REQ-032 The bench SHALL check: 0xFFFF + 0x0001, cin=0 -> result=0x0000, cout=1, overflow=0; then 0x7FFF + 0x0001 -> result=0x8000, cout=0, overflow=1.
REQ-033 The bench SHALL check: sub=1, 0x0005 - 0x0007 -> result=0xFFFE, cout=0; then sub=1, 0x8000 - 0x0001 -> result=0x7FFF, overflow=1, cout=1.
REQ-034 The bench SHALL check: start with new operands during ADD cycle 2 -> ignored; first result is unchanged and done pulses once.
REQ-035 The bench SHALL check: rst pulse during ADD cycle 3 -> all outputs 0 immediately, no done; next start 0x0001 + 0x0001 -> 0x0002.
REQ-036 The bench SHALL check: start held high continuously -> operations complete every 5 cycles, each done a single-cycle pulse with correct results.
